// File: rtl/tone_seq_pkg.sv
// Shared types and default constants for the tone sequencer.
package tone_seq_pkg;

    // Playback controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_VOICES  = 2;
    localparam int DEF_SAMPLE_W    = 32;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_PERIOD_W    = 19;
    localparam int DEF_SONG_LEN    = 1000;
    localparam int DEF_BEAT_CYCLES = 2500000;
    localparam int DEF_AMPLITUDE   = 100000000;

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period register, clock counter, phase bit
// and the signed contribution it adds to the mix.
module tone_voice
    import tone_seq_pkg::*;
#(
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int AMPLITUDE = DEF_AMPLITUDE
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       run,
    input  logic                       enable,
    input  logic [PERIOD_W-1:0]        period_in,
    output logic signed [SAMPLE_W-1:0] contrib
);

    localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] AMP_NEG = -AMP_POS;

    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] count_reg;
    logic                phase_reg;
    logic                is_rest;

    assign is_rest = (period_reg == '0);

    // Period capture on note load; toggle phase every period_reg clocks while playing
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            period_reg <= '0;
            count_reg  <= '0;
            phase_reg  <= 1'b0;
        end else if (clear) begin
            period_reg <= '0;
            count_reg  <= '0;
            phase_reg  <= 1'b0;
        end else if (load) begin
            period_reg <= period_in;
            count_reg  <= '0;
            phase_reg  <= 1'b0;
        end else if (run && !is_rest) begin
            if (count_reg == period_reg - PERIOD_W'(1)) begin
                count_reg <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                count_reg <= count_reg + PERIOD_W'(1);
            end
        end
    end

    // Rests and muted voices add nothing; muting leaves the counter running
    always_comb begin
        contrib = '0;
        if (!is_rest && enable) begin
            contrib = phase_reg ? AMP_POS : AMP_NEG;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice square-wave song player: walks a note ROM one entry per beat,
// mixes the voices with saturation and streams samples to the codec FIFO.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NUM_VOICES  = DEF_NUM_VOICES,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int SONG_LEN    = DEF_SONG_LEN,
    parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
    parameter int AMPLITUDE   = DEF_AMPLITUDE
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           loop_en,
    input  logic [NUM_VOICES-1:0]          voice_en,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [NUM_VOICES*PERIOD_W-1:0] rom_q,
    input  logic                           audio_out_allowed,
    output logic                           write_audio_out,
    output logic [SAMPLE_W-1:0]            left_channel_audio_out,
    output logic [SAMPLE_W-1:0]            right_channel_audio_out,
    output logic                           busy,
    output logic                           song_done
);

    // Wide enough that summing NUM_VOICES full-scale values cannot overflow
    localparam int MIX_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

    seq_state_t                  state_reg;
    logic [ADDR_W-1:0]           rom_addr_reg;
    logic [BEAT_W-1:0]           beat_reg;
    logic                        busy_reg;
    logic                        song_done_reg;
    logic                        write_reg;
    logic [SAMPLE_W-1:0]         sample_reg;

    logic signed [SAMPLE_W-1:0]  contrib_arr [NUM_VOICES];
    logic signed [MIX_W-1:0]     mix_sum;
    logic [SAMPLE_W-1:0]         mix_sat;
    logic                        voice_clear;
    logic                        voice_load;
    logic                        voice_run;
    logic                        beat_end;
    logic                        last_entry;

    // Voices are wiped while idle so a fresh start begins from silence
    assign voice_clear = stop || (state_reg == ST_IDLE);
    assign voice_load  = (state_reg == ST_LOAD);
    assign voice_run   = (state_reg == ST_PLAY);
    assign beat_end    = (beat_reg == BEAT_W'(BEAT_CYCLES - 1));
    assign last_entry  = (rom_addr_reg == ADDR_W'(SONG_LEN - 1));

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            tone_voice #(
                .PERIOD_W  (PERIOD_W),
                .SAMPLE_W  (SAMPLE_W),
                .AMPLITUDE (AMPLITUDE)
            ) u_voice (
                .CLOCK_50  (CLOCK_50),
                .resetn    (resetn),
                .clear     (voice_clear),
                .load      (voice_load),
                .run       (voice_run),
                .enable    (voice_en[gi]),
                .period_in (rom_q[gi*PERIOD_W +: PERIOD_W]),
                .contrib   (contrib_arr[gi])
            );
        end
    endgenerate

    // Sign-extended sum of all voices, clamped to the signed sample range
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_sum = mix_sum + MIX_W'(contrib_arr[i]);
        end
        if (mix_sum > SAT_MAX) begin
            mix_sat = SAT_MAX[SAMPLE_W-1:0];
        end else if (mix_sum < SAT_MIN) begin
            mix_sat = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            mix_sat = mix_sum[SAMPLE_W-1:0];
        end
    end

    // Playback FSM with registered address, status and sample outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            rom_addr_reg  <= '0;
            beat_reg      <= '0;
            busy_reg      <= 1'b0;
            song_done_reg <= 1'b0;
            write_reg     <= 1'b0;
            sample_reg    <= '0;
        end else begin
            song_done_reg <= 1'b0;
            if (stop) begin
                state_reg    <= ST_IDLE;
                rom_addr_reg <= '0;
                beat_reg     <= '0;
                busy_reg     <= 1'b0;
                write_reg    <= 1'b0;
                sample_reg   <= '0;
            end else begin
                if (busy_reg && audio_out_allowed) begin
                    write_reg  <= 1'b1;
                    sample_reg <= mix_sat;
                end else begin
                    write_reg  <= 1'b0;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            rom_addr_reg <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        state_reg <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        beat_reg  <= '0;
                        state_reg <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (beat_end) begin
                            beat_reg <= '0;
                            if (!last_entry) begin
                                rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
                                state_reg    <= ST_FETCH;
                            end else if (loop_en) begin
                                rom_addr_reg <= '0;
                                state_reg    <= ST_FETCH;
                            end else begin
                                rom_addr_reg  <= '0;
                                busy_reg      <= 1'b0;
                                song_done_reg <= 1'b1;
                                write_reg     <= 1'b0;
                                sample_reg    <= '0;
                                state_reg     <= ST_IDLE;
                            end
                        end else begin
                            beat_reg <= beat_reg + BEAT_W'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign rom_addr                = rom_addr_reg;
    assign busy                    = busy_reg;
    assign song_done               = song_done_reg;
    assign write_audio_out         = write_reg;
    assign left_channel_audio_out  = sample_reg;
    assign right_channel_audio_out = sample_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a behavioural model predicts every
// clock's outputs, queues them, and they are compared after the edge.
module tb_tone_sequencer;

    localparam int  NV    = 2;
    localparam int  SW    = 32;
    localparam int  AW    = 4;
    localparam int  PW    = 8;
    localparam int  LEN   = 3;
    localparam int  BEAT  = 16;
    localparam int  AMP   = 1 << 30;

    typedef struct {
        logic [AW-1:0] addr;
        logic          busy;
        logic          done;
        logic          wr;
        logic [SW-1:0] sample;
    } exp_t;

    logic              CLOCK_50 = 1'b0;
    logic              resetn;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [NV-1:0]     voice_en;
    logic [AW-1:0]     rom_addr;
    logic [NV*PW-1:0]  rom_q = '0;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [SW-1:0]     left_channel_audio_out;
    logic [SW-1:0]     right_channel_audio_out;
    logic              busy;
    logic              song_done;

    logic [NV*PW-1:0]  rom_mem [16];

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_cnt     = 0;
    int txn_cnt      = 0;
    exp_t exp_q[$];

    // Reference model state
    int            m_state;
    logic [AW-1:0] m_addr;
    int            m_k;
    int            m_per [NV];
    logic          m_busy;
    logic          m_wr;
    logic [SW-1:0] m_out;

    always #5 CLOCK_50 = ~CLOCK_50;

    // Note ROM with one clock of read latency
    always @(posedge CLOCK_50) rom_q <= rom_mem[rom_addr];

    tone_sequencer #(
        .NUM_VOICES  (NV),
        .SAMPLE_W    (SW),
        .ADDR_W      (AW),
        .PERIOD_W    (PW),
        .SONG_LEN    (LEN),
        .BEAT_CYCLES (BEAT),
        .AMPLITUDE   (AMP)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .resetn                  (resetn),
        .start                   (start),
        .stop                    (stop),
        .loop_en                 (loop_en),
        .voice_en                (voice_en),
        .rom_addr                (rom_addr),
        .rom_q                   (rom_q),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .busy                    (busy),
        .song_done               (song_done)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_addr  = '0;
        m_k     = 0;
        for (int v = 0; v < NV; v++) m_per[v] = 0;
        m_busy  = 1'b0;
        m_wr    = 1'b0;
        m_out   = '0;
    endtask

    // Phase of a voice after k playing clocks with half-period p is (k/p) mod 2
    function automatic logic [SW-1:0] model_mix();
        longint s = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_per[v] != 0 && voice_en[v]) begin
                if (((m_k / m_per[v]) % 2) == 1) s = s + longint'(AMP);
                else                             s = s - longint'(AMP);
            end
        end
        if (s > 64'sd2147483647)       s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[SW-1:0];
    endfunction

    // Predict the post-edge outputs, advance one clock, compare
    task automatic tick();
        logic [SW-1:0]    mix_now;
        logic [NV*PW-1:0] entry;
        exp_t             e;
        exp_t             got;
        logic             m_done;
        mix_now = model_mix();
        m_done  = 1'b0;
        if (stop) begin
            m_state = 0;
            m_addr  = '0;
            m_k     = 0;
            for (int v = 0; v < NV; v++) m_per[v] = 0;
            m_busy  = 1'b0;
            m_wr    = 1'b0;
            m_out   = '0;
        end else begin
            if (m_busy && audio_out_allowed) begin
                m_wr  = 1'b1;
                m_out = mix_now;
            end else begin
                m_wr = 1'b0;
            end
            case (m_state)
                0: begin
                    for (int v = 0; v < NV; v++) m_per[v] = 0;
                    m_k = 0;
                    if (start) begin
                        m_addr  = '0;
                        m_busy  = 1'b1;
                        m_state = 1;
                    end
                end
                1: m_state = 2;
                2: begin
                    entry = rom_mem[m_addr];
                    for (int v = 0; v < NV; v++) m_per[v] = int'(entry[v*PW +: PW]);
                    m_k     = 0;
                    m_state = 3;
                end
                default: begin
                    m_k = m_k + 1;
                    if (m_k == BEAT) begin
                        if (m_addr < AW'(LEN - 1)) begin
                            m_addr  = m_addr + 1'b1;
                            m_state = 1;
                        end else if (loop_en) begin
                            m_addr  = '0;
                            m_state = 1;
                        end else begin
                            m_addr  = '0;
                            m_busy  = 1'b0;
                            m_done  = 1'b1;
                            m_wr    = 1'b0;
                            m_out   = '0;
                            m_state = 0;
                        end
                    end
                end
            endcase
        end
        e.addr   = m_addr;
        e.busy   = m_busy;
        e.done   = m_done;
        e.wr     = m_wr;
        e.sample = m_out;
        exp_q.push_back(e);
        @(posedge CLOCK_50);
        #1;
        got = exp_q.pop_front();
        check_value("rom_addr",  64'(rom_addr),                got.addr);
        check_value("busy",      64'(busy),                    got.busy);
        check_value("song_done", 64'(song_done),               got.done);
        check_value("write",     64'(write_audio_out),         got.wr);
        check_value("left",      64'(left_channel_audio_out),  got.sample);
        check_value("right",     64'(right_channel_audio_out), got.sample);
        if (song_done) done_cnt++;
        if (write_audio_out) begin
            txn_cnt++;
            $display("txn %0d: addr=%0d sample=%0d", txn_cnt, rom_addr, $signed(left_channel_audio_out));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = '0;
        rom_mem[0] = {8'd4, 8'd4};   // equal periods: sums saturate / hit full negative
        rom_mem[1] = {8'd0, 8'd4};   // voice 1 rests
        rom_mem[2] = {8'd8, 8'd3};   // independent phases
        resetn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        voice_en = 2'b01;
        audio_out_allowed = 1'b1;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_value("rst_addr",  64'(rom_addr),               0);
        check_value("rst_busy",  64'(busy),                   0);
        check_value("rst_write", 64'(write_audio_out),        0);
        check_value("rst_left",  64'(left_channel_audio_out), 0);
        check_value("rst_done",  64'(song_done),              0);
        resetn = 1'b1;

        // Single audible voice, no loop: three entries then one done pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check_value("done_once", 64'(done_cnt), 1);

        // Both voices, looping; a start while busy is ignored
        voice_en = 2'b11;
        loop_en  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (100) tick();

        // Back-pressure: writes stop and samples hold, then resume
        audio_out_allowed = 1'b0;
        repeat (10) tick();
        audio_out_allowed = 1'b1;
        repeat (5) tick();

        // Mute voice 0 mid-note; it must keep its timing
        voice_en = 2'b10;
        repeat (10) tick();
        voice_en = 2'b11;
        repeat (4) tick();

        // Stop wins over a simultaneous start
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_value("loop_no_done", 64'(done_cnt), 1);

        // Reset while fetching clears everything at once
        start = 1'b1;
        tick();
        start = 1'b0;
        resetn = 1'b0;
        #1;
        check_value("arst_addr",  64'(rom_addr),                0);
        check_value("arst_busy",  64'(busy),                    0);
        check_value("arst_write", 64'(write_audio_out),         0);
        check_value("arst_left",  64'(left_channel_audio_out),  0);
        check_value("arst_right", 64'(right_channel_audio_out), 0);
        model_reset();
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        repeat (5) tick();

        // Fresh start after reset plays normally
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 2, number of square-wave voices mixed.
REQ-002 SHALL have parameter SAMPLE_W, default 32, signed audio sample width.
REQ-003 SHALL have parameter ADDR_W, default 10, note ROM address width.
REQ-004 SHALL have parameter PERIOD_W, default 19, per-voice half-period field width in clocks.
REQ-005 SHALL have parameter SONG_LEN, default 1000, number of note entries (at most 2^ADDR_W).
REQ-006 SHALL have parameter BEAT_CYCLES, default 2500000, clocks per note entry.
REQ-007 SHALL have parameter AMPLITUDE, default 100000000, per-voice signed peak value.
REQ-008 SHALL have port CLOCK_50, input, 1 bit, sole clock, rising edge.
REQ-009 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port start, input, 1 bit, begin playback from entry 0 (level sampled each clock).
REQ-011 SHALL have port stop, input, 1 bit, abort playback.
REQ-012 SHALL have port loop_en, input, 1 bit, 1 = wrap to entry 0 after the last entry.
REQ-013 SHALL have port voice_en, input, NUM_VOICES bits, per-voice mute (0 = muted).
REQ-014 SHALL have port rom_addr, output, ADDR_W bits, note ROM address.
REQ-015 SHALL have port rom_q, input, NUM_VOICES*PERIOD_W bits, half-periods; voice i in bits [i*PERIOD_W +: PERIOD_W]; one-clock read latency.
REQ-016 SHALL have port audio_out_allowed, input, 1 bit, codec FIFO has room.
REQ-017 SHALL have port write_audio_out, output, 1 bit, sample write strobe.
REQ-018 SHALL have ports left_channel_audio_out and right_channel_audio_out, output, SAMPLE_W bits each, identical mixed sample.
REQ-019 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-020 SHALL have port song_done, output, 1 bit, one-clock pulse at the end of a non-looping song.

Function
REQ-021 SHALL implement the states IDLE, FETCH, LOAD and PLAY.
REQ-022 IDLE: start=1 SHALL set rom_addr=0 and go to FETCH; otherwise remain in IDLE.
REQ-023 FETCH SHALL hold rom_addr for exactly one clock, then go to LOAD.
REQ-024 LOAD SHALL capture rom_q into the per-voice period registers, clear all voice counters and phases to 0 and the beat counter to 0, then go to PLAY.
REQ-025 PLAY SHALL increment the beat counter each clock; at count BEAT_CYCLES-1 it SHALL act as follows:
- rom_addr<SONG_LEN-1: rom_addr+1, go to FETCH.
- rom_addr=SONG_LEN-1 and loop_en=1: rom_addr=0, go to FETCH.
- rom_addr=SONG_LEN-1 and loop_en=0: song_done=1 for one clock, go to IDLE.
REQ-026 In PLAY, each voice whose period P≠0 SHALL count clocks and, when its counter reaches P-1, toggle its phase and clear the counter; the toggle interval is therefore P clocks.
REQ-027 A voice with P=0 (rest) SHALL contribute 0 to the mix, as SHALL a voice with voice_en=0; a muted voice SHALL keep counting.
REQ-028 Each active voice SHALL contribute +AMPLITUDE when its phase is 1 and -AMPLITUDE when its phase is 0; the contributions SHALL be summed in SAMPLE_W+clog2(NUM_VOICES)+1 bits and saturated to the signed SAMPLE_W range.
REQ-029 When audio_out_allowed=1 and busy=1, write_audio_out SHALL be 1 on the next clock, and both channel outputs SHALL be registered with the current mix in that same cycle; otherwise write_audio_out SHALL be 0 and the outputs SHALL hold their values.
REQ-030 In IDLE, the channel outputs SHALL be 0 and write_audio_out SHALL be 0.
REQ-031 stop=1 in any state SHALL go to IDLE on the next clock with rom_addr=0 and the outputs zeroed; stop takes priority over start and over a beat end in the same clock.
REQ-032 start=1 while busy SHALL be ignored.

Reset
REQ-033 resetn=0 SHALL asynchronously force IDLE and set rom_addr, all counters, phases and periods, write_audio_out, busy, song_done and both channel outputs to 0.
REQ-034 Reset deasserted mid-song SHALL NOT resume playback; a new start is required.

Structure
REQ-035 Package tone_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Each voice (period register, counter, phase, signed contribution) SHALL be one sub-module, tone_voice, instantiated NUM_VOICES times via generate.

Verification
REQ-037 NUM_VOICES=1, BEAT_CYCLES=16, P=4, start pulse -> phase toggles every 4 clocks, output alternates ±AMPLITUDE, rom_addr advances after 16 PLAY clocks.
REQ-038 SONG_LEN=3, loop_en=0 -> rom_addr sequence 0,1,2, one song_done pulse, busy falls, outputs 0.
REQ-039 SONG_LEN=3, loop_en=1 -> rom_addr wraps 2→0, no song_done, busy stays 1.
REQ-040 NUM_VOICES=2, AMPLITUDE=2^30, SAMPLE_W=32, both phases 1 -> output saturates at 2^31-1; one voice at P=0 -> output = 2^30.
REQ-041 audio_out_allowed held 0 for 10 clocks -> write_audio_out stays 0 and outputs hold; rising edge -> strobe on the next clock.
REQ-042 Assert stop during PLAY and resetn=0 during FETCH -> IDLE with all outputs 0 on the next clock (stop) and immediately (reset).
